// File: rtl/amp_gain_monitor.sv
// Peak-to-peak gain monitor: tracks signed extremes of paired In/Out ADC samples
// over a 2^LOG2_WIN window and hands out one result per window through valid/ready.
//
// state | meaning
// IDLE  | samples ignored, waiting for start
// ACQ   | accepting samples, updating extremes, counting the window
module amp_gain_monitor #(
  parameter int W        = 12,
  parameter int LOG2_WIN = 8,
  parameter int GAIN_THR = 20
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  input  logic                cont,
  input  logic                smp_valid,
  input  logic signed [W-1:0] in_smp,
  input  logic signed [W-1:0] out_smp,
  output logic                res_valid,
  input  logic                res_ready,
  output logic [W:0]          in_pp,
  output logic [W:0]          out_pp,
  output logic                gain_low,
  output logic                busy,
  output logic                overrun
);

  typedef enum logic {IDLE, ACQ} state_t;

  localparam logic signed [W-1:0] S_MIN    = {1'b1, {(W-1){1'b0}}};
  localparam logic signed [W-1:0] S_MAX    = {1'b0, {(W-1){1'b1}}};
  localparam logic [LOG2_WIN-1:0] CNT_LAST = '1;
  localparam logic [W+16:0]       THR      = (W+17)'(GAIN_THR);

  state_t                state_q, state_d;
  logic [LOG2_WIN-1:0]   cnt_q;
  logic signed [W-1:0]   max_in_q, min_in_q, max_out_q, min_out_q;
  logic signed [W-1:0]   max_in_n, min_in_n, max_out_n, min_out_n;
  logic [W:0]            pp_in_n, pp_out_n;
  logic [W+16:0]         thr_prod;
  logic                  gain_low_n;
  logic                  accept, win_done;

  // start overrides any sample in the same cycle, including the window's last one
  assign accept   = (state_q == ACQ) && smp_valid && !start;
  assign win_done = accept && (cnt_q == CNT_LAST);

  assign max_in_n  = (in_smp  > max_in_q)  ? in_smp  : max_in_q;
  assign min_in_n  = (in_smp  < min_in_q)  ? in_smp  : min_in_q;
  assign max_out_n = (out_smp > max_out_q) ? out_smp : max_out_q;
  assign min_out_n = (out_smp < min_out_q) ? out_smp : min_out_q;

  assign pp_in_n    = {max_in_n[W-1],  max_in_n}  - {min_in_n[W-1],  min_in_n};
  assign pp_out_n   = {max_out_n[W-1], max_out_n} - {min_out_n[W-1], min_out_n};
  assign thr_prod   = (W+17)'(pp_in_n) * THR;
  assign gain_low_n = (W+17)'(pp_out_n) < thr_prod;

  assign busy = (state_q == ACQ);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (start)                 state_d = ACQ;
    else if (win_done && !cont) state_d = IDLE;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q     <= '0;
      max_in_q  <= S_MIN;
      min_in_q  <= S_MAX;
      max_out_q <= S_MIN;
      min_out_q <= S_MAX;
    end else if (start || win_done) begin
      // reload at window completion too, so a continuous window loses no sample
      cnt_q     <= '0;
      max_in_q  <= S_MIN;
      min_in_q  <= S_MAX;
      max_out_q <= S_MIN;
      min_out_q <= S_MAX;
    end else if (accept) begin
      cnt_q     <= cnt_q + LOG2_WIN'(1);
      max_in_q  <= max_in_n;
      min_in_q  <= min_in_n;
      max_out_q <= max_out_n;
      min_out_q <= min_out_n;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      res_valid <= 1'b0;
      in_pp     <= '0;
      out_pp    <= '0;
      gain_low  <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      if (start) overrun <= 1'b0;
      if (win_done) begin
        if (!res_valid || res_ready) begin
          res_valid <= 1'b1;
          in_pp     <= pp_in_n;
          out_pp    <= pp_out_n;
          gain_low  <= gain_low_n;
        end else begin
          overrun   <= 1'b1;
        end
      end else if (res_valid && res_ready) begin
        res_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_amp_gain_monitor.sv
// Bench for amp_gain_monitor: reference model + result scoreboard, a table of
// sine-window vectors and hand-written overrun / pop-push / restart / reset sequences.
module tb_amp_gain_monitor;
  localparam int W = 12;
  localparam int LOG2_WIN = 4;
  localparam int GAIN_THR = 20;
  localparam int WIN = 1 << LOG2_WIN;

  logic                clk = 1'b0;
  logic                rst_n = 1'b0;
  logic                start = 1'b0;
  logic                cont = 1'b0;
  logic                smp_valid = 1'b0;
  logic signed [W-1:0] in_smp = '0;
  logic signed [W-1:0] out_smp = '0;
  logic                res_valid;
  logic                res_ready = 1'b0;
  logic [W:0]          in_pp;
  logic [W:0]          out_pp;
  logic                gain_low;
  logic                busy;
  logic                overrun;

  amp_gain_monitor #(.W(W), .LOG2_WIN(LOG2_WIN), .GAIN_THR(GAIN_THR)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .cont(cont), .smp_valid(smp_valid),
    .in_smp(in_smp), .out_smp(out_smp), .res_valid(res_valid), .res_ready(res_ready),
    .in_pp(in_pp), .out_pp(out_pp), .gain_low(gain_low), .busy(busy), .overrun(overrun)
  );

  always #5 clk = ~clk;

  typedef struct { int ip; int op; bit gl; } exp_t;
  typedef struct { int in_a; int out_a; int exp_in; int exp_out; bit exp_low; } vec_t;

  exp_t sb_q[$];
  exp_t e;
  int   errors = 0;
  int   checks = 0;

  // reference model
  bit m_act = 0, m_rv = 0, m_ovr = 0;
  int m_cnt = 0;
  int m_max_in, m_min_in, m_max_out, m_min_out;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic m_clear();
    m_cnt = 0;
    m_max_in = -(1 << (W-1)); m_min_in = (1 << (W-1)) - 1;
    m_max_out = -(1 << (W-1)); m_min_out = (1 << (W-1)) - 1;
  endtask

  // apply one cycle of stimulus, advance the model, then check control outputs
  task automatic step(input bit st, input bit v, input int a, input int b);
    bit comp;
    exp_t r;
    start = st; smp_valid = v; in_smp = W'(a); out_smp = W'(b);
    comp = 0;
    if (st) begin
      m_act = 1; m_ovr = 0; m_clear();
    end else if (m_act && v) begin
      if (a > m_max_in) m_max_in = a;
      if (a < m_min_in) m_min_in = a;
      if (b > m_max_out) m_max_out = b;
      if (b < m_min_out) m_min_out = b;
      if (m_cnt == WIN-1) begin
        comp = 1;
        r.ip = m_max_in - m_min_in;
        r.op = m_max_out - m_min_out;
        r.gl = (longint'(r.op) < longint'(r.ip) * GAIN_THR);
        m_clear();
        if (!cont) m_act = 0;
      end else m_cnt++;
    end
    if (comp) begin
      if (!m_rv || res_ready) begin sb_q.push_back(r); m_rv = 1; end
      else m_ovr = 1;
    end else if (m_rv && res_ready) m_rv = 0;
    @(posedge clk); #1;
    start = 0;
    chk("res_valid", res_valid, m_rv);
    chk("busy", busy, m_act);
    chk("overrun", overrun, m_ovr);
  endtask

  task automatic sine_window(input int a, input int b);
    for (int i = 0; i < WIN; i++) step(0, 1, (i % 2 == 0) ? a : -a, (i % 2 == 0) ? b : -b);
  endtask

  task automatic do_reset();
    rst_n = 0;
    #2;
    chk("rst_res_valid", res_valid, 0);
    chk("rst_in_pp", in_pp, 0);
    chk("rst_out_pp", out_pp, 0);
    chk("rst_gain_low", gain_low, 0);
    chk("rst_busy", busy, 0);
    chk("rst_overrun", overrun, 0);
    m_act = 0; m_rv = 0; m_ovr = 0; m_clear();
    sb_q.delete();
    @(negedge clk); rst_n = 1;
    @(posedge clk); #1;
  endtask

  always @(negedge clk) begin
    if (rst_n && res_valid && res_ready) begin
      if (sb_q.size() == 0) begin
        checks++; errors++;
        $display("FAIL sb_pop: got result in_pp=%0d with no expected entry", in_pp);
      end else begin
        e = sb_q.pop_front();
        chk("sb_in_pp", in_pp, e.ip);
        chk("sb_out_pp", out_pp, e.op);
        chk("sb_gain_low", gain_low, e.gl);
      end
    end
  end

  vec_t tbl[6];

  initial begin
    tbl[0] = '{10, 300, 20, 600, 0};
    tbl[1] = '{10, 150, 20, 300, 1};
    tbl[2] = '{10, 200, 20, 400, 0};
    tbl[3] = '{10, 199, 20, 398, 1};
    tbl[4] = '{0, 0, 0, 0, 0};
    tbl[5] = '{2047, 2047, 4094, 4094, 1};

    m_clear();
    #3;
    do_reset();

    // table-driven one-shot windows
    cont = 0; res_ready = 1;
    foreach (tbl[k]) begin
      step(1, 0, 0, 0);
      sine_window(tbl[k].in_a, tbl[k].out_a);
      step(0, 0, 0, 0);
      chk("tbl_in_pp", in_pp, tbl[k].exp_in);
      chk("tbl_out_pp", out_pp, tbl[k].exp_out);
      chk("tbl_gain_low", gain_low, tbl[k].exp_low);
    end

    // full-scale extremes with random gaps in smp_valid
    begin
      int k;
      bit v;
      int a;
      k = 0;
      step(1, 0, 0, 0);
      while (k < WIN) begin
        v = $urandom_range(0, 1);
        a = (k == 3) ? -2048 : (k == 9) ? 2047 : int'($urandom_range(0, 200)) - 100;
        step(0, v, a, int'($urandom_range(0, 2000)) - 1000);
        if (v) k++;
      end
      step(0, 0, 0, 0);
      chk("extreme_in_pp", in_pp, 4095);
    end

    // overrun: two continuous windows with consumer stalled
    cont = 1; res_ready = 0;
    step(1, 0, 0, 0);
    sine_window(5, 100);
    sine_window(7, 50);
    chk("ovr_hold_in_pp", in_pp, 10);
    chk("ovr_hold_out_pp", out_pp, 200);
    chk("ovr_flag", overrun, 1);
    cont = 0;
    step(1, 0, 0, 0);
    res_ready = 1;
    step(0, 0, 0, 0);
    sine_window(1, 30);
    step(0, 0, 0, 0);

    // same-cycle pop and push at the second window's completion
    cont = 1; res_ready = 0;
    step(1, 0, 0, 0);
    sine_window(4, 80);
    for (int i = 0; i < WIN-1; i++) step(0, 1, (i % 2 == 0) ? 6 : -6, (i % 2 == 0) ? 50 : -50);
    res_ready = 1;
    step(0, 1, -6, -50);
    res_ready = 0;
    chk("popush_in_pp", in_pp, 12);
    chk("popush_gain_low", gain_low, 1);
    chk("popush_valid", res_valid, 1);
    cont = 0; res_ready = 1;
    step(1, 0, 0, 0);
    sine_window(2, 2);
    step(0, 0, 0, 0);

    // restart mid-window: only post-start samples count
    step(1, 0, 0, 0);
    for (int i = 0; i < 7; i++) step(0, 1, (i % 2 == 0) ? 1000 : -1000, 1000);
    step(1, 1, 1000, 1000);
    sine_window(3, 90);
    step(0, 0, 0, 0);
    chk("restart_in_pp", in_pp, 6);
    chk("restart_out_pp", out_pp, 180);

    // reset in the middle of a window
    step(1, 0, 0, 0);
    for (int i = 0; i < 9; i++) step(0, 1, 500, 500);
    do_reset();
    for (int i = 0; i < 2*WIN; i++) step(0, 1, i, -i);

    chk("sb_drained", sb_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
